// File: rtl/video_scale_pkg.sv
// Shared types and helpers for the video decimate-and-pack path.
package video_scale_pkg;

  localparam int DIM_W = 12;

  typedef logic [15:0] rgb565_t;

  // One VDMA word: earlier pixel in the low half.
  typedef struct packed {
    rgb565_t hi;
    rgb565_t lo;
  } word_t;

  function automatic rgb565_t rgb888_to_565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

endpackage

// File: rtl/video_scale_pack_decim_acc.sv
// Nearest-neighbour decimation stepper: keep is live for the current acc,
// acc advances by out (wrapping by in) on step.
module decim_acc #(
  parameter int W = video_scale_pkg::DIM_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         step_i,
  input  logic [W-1:0] in_size_i,
  input  logic [W-1:0] out_size_i,
  output logic         keep_o
);

  logic [W:0]   acc_q, acc_d, sum;
  logic [W-1:0] out_eff;

  always_comb begin
    out_eff = (out_size_i > in_size_i) ? in_size_i : out_size_i;
    sum     = acc_q + {1'b0, out_eff};
    // out=0 must never keep, even when in=0 makes the compare trivially true
    keep_o  = (out_eff != '0) && (sum >= {1'b0, in_size_i});
    acc_d   = acc_q;
    if (clr_i)       acc_d = '0;
    else if (step_i) acc_d = keep_o ? sum - {1'b0, in_size_i} : sum;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/video_scale_pack.sv
// RGB888 stream -> decimated RGB565, two pixels per word, onto the VDMA write port.
module video_scale_pack #(
  parameter int PIX_DW      = 24,
  parameter int W_DATAWIDTH = 32,
  parameter int DIM_W       = video_scale_pkg::DIM_W
) (
  input  logic                   W_wclk_i,
  input  logic                   W_rst_i,
  input  logic                   vs_i,
  input  logic                   de_i,
  input  logic [PIX_DW-1:0]      data_i,
  input  logic [DIM_W-1:0]       in_xsize_i,
  input  logic [DIM_W-1:0]       in_ysize_i,
  input  logic [DIM_W-1:0]       out_xsize_i,
  input  logic [DIM_W-1:0]       out_ysize_i,
  input  logic                   W_full_i,
  output logic                   W_FS_o,
  output logic                   W_wren_o,
  output logic [W_DATAWIDTH-1:0] W_data_o,
  output logic                   ovf_o,
  output logic [7:0]             frame_cnt_o
);
  import video_scale_pkg::*;

  if (W_DATAWIDTH != 32 || PIX_DW != 24) begin : g_bad_cfg
    $error("video_scale_pack supports only RGB888 in, 2xRGB565 (32-bit) out");
  end

  logic             vs_q, de_q, armed_q, fs_q;
  logic             vs_rise, de_rise, de_fall, flush;
  logic [DIM_W-1:0] in_x_q, in_y_q, out_x_q, out_y_q;
  logic             hkeep, vkeep, line_keep_q, line_keep;
  logic             s1_vld_q;
  logic [PIX_DW-1:0] s1_data_q;
  rgb565_t          px, lo_q, lo_d;
  logic             pend_q, pend_d, due;
  logic             wren_q, wren_d, ovf_q, ovf_d;
  word_t            data_q, word_d;
  logic [7:0]       fcnt_q;

  assign vs_rise   = vs_i & ~vs_q;
  assign de_rise   = de_i & ~de_q;
  assign de_fall   = ~de_i & de_q;
  // first pixel of a line arrives with de_rise, before line_keep_q is loaded
  assign line_keep = de_rise ? vkeep : line_keep_q;
  assign flush     = armed_q & de_fall & ~vs_rise;
  assign px        = rgb888_to_565(s1_data_q);

  decim_acc #(.W(DIM_W)) u_hacc (
    .clk_i      (W_wclk_i),
    .rst_i      (W_rst_i),
    .clr_i      (vs_rise | de_fall),
    .step_i     (armed_q & de_i & ~vs_rise),
    .in_size_i  (in_x_q),
    .out_size_i (out_x_q),
    .keep_o     (hkeep)
  );

  decim_acc #(.W(DIM_W)) u_vacc (
    .clk_i      (W_wclk_i),
    .rst_i      (W_rst_i),
    .clr_i      (vs_rise),
    .step_i     (armed_q & de_fall & ~vs_rise),
    .in_size_i  (in_y_q),
    .out_size_i (out_y_q),
    .keep_o     (vkeep)
  );

  // Pack stage: a frame start discards both the pending half and any pixel in flight.
  always_comb begin
    pend_d = pend_q;
    lo_d   = lo_q;
    ovf_d  = ovf_q;
    word_d = data_q;
    wren_d = 1'b0;
    due    = 1'b0;
    if (vs_rise) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (s1_vld_q) begin
        if (pend_q) begin
          due    = 1'b1;
          word_d = '{hi: px, lo: lo_q};
          pend_d = 1'b0;
        end else if (flush) begin
          due    = 1'b1;
          word_d = '{hi: '0, lo: px};
        end else begin
          lo_d   = px;
          pend_d = 1'b1;
        end
      end else if (flush && pend_q) begin
        due    = 1'b1;
        word_d = '{hi: '0, lo: lo_q};
        pend_d = 1'b0;
      end
      if (due) begin
        if (W_full_i) ovf_d  = 1'b1;
        else          wren_d = 1'b1;
      end
    end
  end

  always_ff @(posedge W_wclk_i) begin
    if (W_rst_i) begin
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      armed_q     <= 1'b0;
      fs_q        <= 1'b0;
      in_x_q      <= '0;
      in_y_q      <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      line_keep_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      pend_q      <= 1'b0;
      lo_q        <= '0;
      wren_q      <= 1'b0;
      ovf_q       <= 1'b0;
      data_q      <= '0;
      fcnt_q      <= '0;
    end else begin
      vs_q   <= vs_i;
      de_q   <= de_i;
      fs_q   <= vs_rise;
      if (vs_rise) begin
        armed_q <= 1'b1;
        in_x_q  <= in_xsize_i;
        in_y_q  <= in_ysize_i;
        out_x_q <= out_xsize_i;
        out_y_q <= out_ysize_i;
        fcnt_q  <= fcnt_q + 8'd1;
      end
      if (de_rise) line_keep_q <= vkeep;
      s1_vld_q <= armed_q & de_i & ~vs_rise & hkeep & line_keep;
      if (de_i) s1_data_q <= data_i;
      pend_q <= pend_d;
      lo_q   <= lo_d;
      wren_q <= wren_d;
      ovf_q  <= ovf_d;
      if (wren_d) data_q <= word_d;
    end
  end

  assign W_FS_o      = fs_q;
  assign W_wren_o    = wren_q;
  assign W_data_o    = data_q;
  assign ovf_o       = ovf_q;
  assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_video_scale_pack.sv
// Directed bench for video_scale_pack: small frames with hand-chosen keep patterns.
module tb_video_scale_pack;

  logic        clk = 1'b0, rst = 1'b1, vs = 1'b0, de = 1'b0, full = 1'b0;
  logic [23:0] data = '0;
  logic [11:0] in_x = '0, in_y = '0, out_x = '0, out_y = '0;
  logic        fs, wren, ovf;
  logic [31:0] wdata;
  logic [7:0]  fcnt;

  int cyc = 0, tests = 0, fails = 0;
  logic [31:0] wq[$];
  int          wt[$];
  int          fsq[$];
  logic [31:0] eq[$];
  bit          kx[32], ky[32];

  video_scale_pack dut (
    .W_wclk_i(clk), .W_rst_i(rst), .vs_i(vs), .de_i(de), .data_i(data),
    .in_xsize_i(in_x), .in_ysize_i(in_y), .out_xsize_i(out_x), .out_ysize_i(out_y),
    .W_full_i(full), .W_FS_o(fs), .W_wren_o(wren), .W_data_o(wdata),
    .ovf_o(ovf), .frame_cnt_o(fcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wren) begin wq.push_back(wdata); wt.push_back(cyc); end
    if (fs) fsq.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] pix(int y, int x);
    logic [7:0] r, g, b;
    r = 8'(x * 8 + y * 3 + 7);
    g = 8'(x * 4 + y * 64 + 1);
    b = 8'(255 - x * 9 - y);
    return {r, g, b};
  endfunction

  function automatic logic [15:0] c565(logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  // Expected word list from the kx/ky keep patterns; words dl:df..dt are dropped.
  task automatic build_exp(input int nx, input int ny, input int dl, input int df, input int dt);
    logic [15:0] lo;
    bit pend;
    int w;
    eq.delete();
    lo = '0;
    for (int y = 0; y < ny; y++) if (ky[y]) begin
      pend = 0; w = 0;
      for (int x = 0; x < nx; x++) if (kx[x]) begin
        if (!pend) begin lo = c565(pix(y, x)); pend = 1; end
        else begin
          if (!(y == dl && w >= df && w <= dt)) eq.push_back({c565(pix(y, x)), lo});
          w++; pend = 0;
        end
      end
      if (pend && !(y == dl && w >= df && w <= dt)) eq.push_back({16'h0000, lo});
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) tick(); endtask

  task automatic vs_pulse(output int c);
    tick(); vs = 1'b1; c = cyc;
    idle(2); vs = 1'b0; idle(3);
  endtask

  task automatic drive_line(input int y, input int nx, input int ff, input int ft,
                            output int c0, output int cl);
    c0 = 0; cl = 0;
    for (int i = 0; i < nx; i++) begin
      tick(); de = 1'b1; data = pix(y, i); full = (i >= ff && i <= ft);
      if (i == 0) c0 = cyc;
      cl = cyc;
    end
    tick(); de = 1'b0; full = 1'b0;
    idle(6);
  endtask

  task automatic sizes(input int ix, input int iy, input int ox, input int oy);
    in_x = 12'(ix); in_y = 12'(iy); out_x = 12'(ox); out_y = 12'(oy);
  endtask

  task automatic test_reset();
    int c0, cl, wb;
    idle(3); rst = 1'b0; tick();
    tests++; if (fs !== 1'b0)    begin fails++; $display("FAIL rst_fs got %b exp 0", fs); end
    tests++; if (wren !== 1'b0)  begin fails++; $display("FAIL rst_wren got %b exp 0", wren); end
    tests++; if (wdata !== '0)   begin fails++; $display("FAIL rst_data got %h exp 0", wdata); end
    tests++; if (ovf !== 1'b0)   begin fails++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    tests++; if (fcnt !== 8'd0)  begin fails++; $display("FAIL rst_fcnt got %0d exp 0", fcnt); end
    sizes(8, 4, 8, 4);
    wb = wq.size();
    drive_line(0, 8, -1, -1, c0, cl);
    tests++; if (wq.size() != wb) begin fails++; $display("FAIL unarmed_words got %0d exp 0", wq.size() - wb); end
  endtask

  task automatic test_copy();
    int c, c0, cl, f0, wb, fb;
    sizes(8, 4, 8, 4);
    wb = wq.size(); fb = fsq.size();
    vs_pulse(c);
    tests++; if (fsq.size() - fb != 1) begin fails++; $display("FAIL copy_fs_cnt got %0d exp 1", fsq.size() - fb); end
    else begin
      tests++; if (fsq[fb] != c + 1) begin fails++; $display("FAIL copy_fs_cyc got %0d exp %0d", fsq[fb], c + 1); end
    end
    tests++; if (fcnt !== 8'd1) begin fails++; $display("FAIL copy_fcnt got %0d exp 1", fcnt); end
    drive_line(0, 8, -1, -1, f0, cl);
    for (int y = 1; y < 4; y++) drive_line(y, 8, -1, -1, c0, cl);
    for (int i = 0; i < 32; i++) begin kx[i] = 1; ky[i] = 1; end
    build_exp(8, 4, -1, -1, -1);
    tests++; if (wq.size() - wb != eq.size()) begin fails++; $display("FAIL copy_count got %0d exp %0d", wq.size() - wb, eq.size()); end
    for (int i = 0; i < eq.size(); i++) if (wb + i < wq.size()) begin
      tests++; if (wq[wb + i] !== eq[i]) begin fails++; $display("FAIL copy_word%0d got %h exp %h", i, wq[wb + i], eq[i]); end
    end
    if (wq.size() > wb) begin
      tests++; if (wt[wb] != f0 + 3) begin fails++; $display("FAIL copy_latency got %0d exp %0d", wt[wb], f0 + 3); end
    end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL copy_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_odd_width();
    int c, c0, cl, l0, wb;
    sizes(10, 2, 5, 2);
    wb = wq.size();
    vs_pulse(c);
    drive_line(0, 10, -1, -1, c0, l0);
    drive_line(1, 10, -1, -1, c0, cl);
    for (int i = 0; i < 32; i++) begin kx[i] = (i % 2 == 1); ky[i] = 1; end
    build_exp(10, 2, -1, -1, -1);
    tests++; if (wq.size() - wb != 6) begin fails++; $display("FAIL odd_count got %0d exp 6", wq.size() - wb); end
    for (int i = 0; i < eq.size(); i++) if (wb + i < wq.size()) begin
      tests++; if (wq[wb + i] !== eq[i]) begin fails++; $display("FAIL odd_word%0d got %h exp %h", i, wq[wb + i], eq[i]); end
    end
    if (wq.size() - wb >= 3) begin
      tests++; if (wq[wb + 2][31:16] !== 16'h0000) begin fails++; $display("FAIL odd_flush_hi got %h exp 0000", wq[wb + 2][31:16]); end
      tests++; if (wt[wb + 2] != l0 + 2) begin fails++; $display("FAIL odd_flush_cyc got %0d exp %0d", wt[wb + 2], l0 + 2); end
    end
    tests++; if (fcnt !== 8'd2) begin fails++; $display("FAIL odd_fcnt got %0d exp 2", fcnt); end
  endtask

  task automatic test_overflow();
    int c, c0, cl, wb;
    sizes(8, 4, 8, 4);
    wb = wq.size();
    vs_pulse(c);
    drive_line(0, 8, -1, -1, c0, cl);
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_before got %b exp 0", ovf); end
    drive_line(1, 8, 2, 7, c0, cl);
    drive_line(2, 8, -1, -1, c0, cl);
    drive_line(3, 8, -1, -1, c0, cl);
    for (int i = 0; i < 32; i++) begin kx[i] = 1; ky[i] = 1; end
    build_exp(8, 4, 1, 0, 2);
    tests++; if (wq.size() - wb != 13) begin fails++; $display("FAIL ovf_count got %0d exp 13", wq.size() - wb); end
    for (int i = 0; i < eq.size(); i++) if (wb + i < wq.size()) begin
      tests++; if (wq[wb + i] !== eq[i]) begin fails++; $display("FAIL ovf_word%0d got %h exp %h", i, wq[wb + i], eq[i]); end
    end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    vs_pulse(c);
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", ovf); end
  endtask

  task automatic test_reconfig();
    int c, c0, cl, wb;
    sizes(8, 4, 8, 4);
    wb = wq.size();
    vs_pulse(c);
    drive_line(0, 8, -1, -1, c0, cl);
    drive_line(1, 8, -1, -1, c0, cl);
    out_x = 12'd4; out_y = 12'd2;
    drive_line(2, 8, -1, -1, c0, cl);
    drive_line(3, 8, -1, -1, c0, cl);
    for (int i = 0; i < 32; i++) begin kx[i] = 1; ky[i] = 1; end
    build_exp(8, 4, -1, -1, -1);
    tests++; if (wq.size() - wb != 16) begin fails++; $display("FAIL reconf_count got %0d exp 16", wq.size() - wb); end
    for (int i = 0; i < eq.size(); i++) if (wb + i < wq.size()) begin
      tests++; if (wq[wb + i] !== eq[i]) begin fails++; $display("FAIL reconf_word%0d got %h exp %h", i, wq[wb + i], eq[i]); end
    end
    // next frame picks up 4x2: odd columns of odd lines
    wb = wq.size();
    vs_pulse(c);
    for (int y = 0; y < 4; y++) drive_line(y, 8, -1, -1, c0, cl);
    for (int i = 0; i < 32; i++) begin kx[i] = (i % 2 == 1); ky[i] = (i % 2 == 1); end
    build_exp(8, 4, -1, -1, -1);
    tests++; if (wq.size() - wb != 4) begin fails++; $display("FAIL down_count got %0d exp 4", wq.size() - wb); end
    for (int i = 0; i < eq.size(); i++) if (wb + i < wq.size()) begin
      tests++; if (wq[wb + i] !== eq[i]) begin fails++; $display("FAIL down_word%0d got %h exp %h", i, wq[wb + i], eq[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int c, c0, cl, wb;
    sizes(8, 4, 8, 4);
    vs_pulse(c);
    for (int i = 0; i < 4; i++) begin tick(); de = 1'b1; data = pix(0, i); end
    tick(); rst = 1'b1; data = pix(0, 4);
    tick(); rst = 1'b0; data = pix(0, 5);
    wb = wq.size();
    tests++; if (wren !== 1'b0)  begin fails++; $display("FAIL midrst_wren got %b exp 0", wren); end
    tests++; if (wdata !== '0)   begin fails++; $display("FAIL midrst_data got %h exp 0", wdata); end
    tests++; if (fcnt !== 8'd0)  begin fails++; $display("FAIL midrst_fcnt got %0d exp 0", fcnt); end
    for (int i = 6; i < 8; i++) begin tick(); data = pix(0, i); end
    tick(); de = 1'b0; idle(6);
    drive_line(1, 8, -1, -1, c0, cl);
    tests++; if (wq.size() != wb) begin fails++; $display("FAIL midrst_words got %0d exp 0", wq.size() - wb); end
    vs_pulse(c);
    tests++; if (fcnt !== 8'd1) begin fails++; $display("FAIL midrst_fcnt_restart got %0d exp 1", fcnt); end
    drive_line(0, 8, -1, -1, c0, cl);
    for (int i = 0; i < 32; i++) begin kx[i] = 1; ky[i] = (i == 0); end
    build_exp(8, 1, -1, -1, -1);
    tests++; if (wq.size() - wb != 4) begin fails++; $display("FAIL midrst_rearm got %0d exp 4", wq.size() - wb); end
    for (int i = 0; i < eq.size(); i++) if (wb + i < wq.size()) begin
      tests++; if (wq[wb + i] !== eq[i]) begin fails++; $display("FAIL midrst_word%0d got %h exp %h", i, wq[wb + i], eq[i]); end
    end
  endtask

  task automatic test_clamp_zero();
    int c, c0, cl, wb, fb;
    sizes(10, 4, 20, 4);
    wb = wq.size();
    vs_pulse(c);
    for (int y = 0; y < 4; y++) drive_line(y, 10, -1, -1, c0, cl);
    for (int i = 0; i < 32; i++) begin kx[i] = 1; ky[i] = 1; end
    build_exp(10, 4, -1, -1, -1);
    tests++; if (wq.size() - wb != 20) begin fails++; $display("FAIL clamp_count got %0d exp 20", wq.size() - wb); end
    for (int i = 0; i < eq.size(); i++) if (wb + i < wq.size()) begin
      tests++; if (wq[wb + i] !== eq[i]) begin fails++; $display("FAIL clamp_word%0d got %h exp %h", i, wq[wb + i], eq[i]); end
    end
    sizes(10, 4, 0, 4);
    wb = wq.size(); fb = fsq.size();
    vs_pulse(c);
    for (int y = 0; y < 4; y++) drive_line(y, 10, -1, -1, c0, cl);
    tests++; if (fsq.size() - fb != 1) begin fails++; $display("FAIL zero_fs got %0d exp 1", fsq.size() - fb); end
    tests++; if (wq.size() != wb) begin fails++; $display("FAIL zero_words got %0d exp 0", wq.size() - wb); end
    tests++; if (fcnt !== 8'd3) begin fails++; $display("FAIL zero_fcnt got %0d exp 3", fcnt); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_odd_width();
    test_overflow();
    test_reconfig();
    test_reset_mid();
    test_clamp_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
